// File: rtl/fmap_channel_packer.sv
`default_nettype none
// ============================================================================
// Module      : fmap_channel_packer
// Description : Collects NUM_CH serial channel samples per pixel and emits one
//               channel-parallel NUM_CH*DATA_WIDTH word per pixel, walking a
//               single IMG_SIZE x IMG_SIZE frame in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_channel_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned IMG_SIZE   = 104
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
  output logic                           valid_out,
  output logic [$clog2(IMG_SIZE)-1:0]    pix_col,
  output logic [$clog2(IMG_SIZE)-1:0]    pix_row,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int unsigned C_PIX_W = $clog2(IMG_SIZE);
  localparam int unsigned C_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                                r_state;
  state_t                                w_state_next;
  logic [C_CH_W-1:0]                     r_ch_cnt;
  logic [C_PIX_W-1:0]                    r_col_cnt;
  logic [C_PIX_W-1:0]                    r_row_cnt;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     r_shadow;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     w_packed;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     r_data_out;
  logic                                  r_valid_out;
  logic                                  r_frame_done;
  logic [C_PIX_W-1:0]                    r_pix_col;
  logic [C_PIX_W-1:0]                    r_pix_row;

  // Handshake is derived from the state register directly so the next-state
  // logic never reads back its own combinational outputs.
  logic w_xfer;
  logic w_last_ch;
  logic w_last_col;
  logic w_last_row;
  logic w_pix_done;
  logic w_frame_end;

  assign w_xfer      = valid_in && (r_state == S_RUN);
  assign w_last_ch   = (r_ch_cnt  == C_CH_W'(NUM_CH - 1));
  assign w_last_col  = (r_col_cnt == C_PIX_W'(IMG_SIZE - 1));
  assign w_last_row  = (r_row_cnt == C_PIX_W'(IMG_SIZE - 1));
  assign w_pix_done  = w_xfer && w_last_ch;
  assign w_frame_end = w_pix_done && w_last_col && w_last_row;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; start is only honoured from IDLE.
  always_comb begin
    w_state_next = r_state;
    ready_out    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        ready_out = 1'b1;
        busy      = 1'b1;
        if (w_frame_end) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The final channel bypasses the shadow so the pixel leaves on the same edge.
  always_comb begin
    w_packed             = r_shadow;
    w_packed[NUM_CH-1]   = data_in;
  end

  // Channel/column/row counters and shadow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt  <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_shadow  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_ch_cnt  <= '0;
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end
    end else if (w_xfer) begin
      r_shadow[r_ch_cnt] <= data_in;
      if (w_last_ch) begin
        r_ch_cnt <= '0;
        if (w_last_col) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_last_row ? '0 : (r_row_cnt + C_PIX_W'(1));
        end else begin
          r_col_cnt <= r_col_cnt + C_PIX_W'(1);
        end
      end else begin
        r_ch_cnt <= r_ch_cnt + C_CH_W'(1);
      end
    end
  end

  // Output word and pixel coordinates; held between completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pix_col    <= '0;
      r_pix_row    <= '0;
    end else begin
      r_valid_out  <= w_pix_done;
      r_frame_done <= w_frame_end;
      if (w_pix_done) begin
        r_data_out <= w_packed;
        r_pix_col  <= r_col_cnt;
        r_pix_row  <= r_row_cnt;
      end
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;
  assign pix_col    = r_pix_col;
  assign pix_row    = r_pix_row;

endmodule
`default_nettype wire

// File: tb/tb_fmap_channel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_channel_packer
// Description : Directed self-checking bench; one instance at NUM_CH=32 and
//               one small instance at NUM_CH=2, IMG_SIZE=4 share the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_channel_packer;

  localparam int DW = 32;
  localparam int NB = 32;
  localparam int IB = 104;
  localparam int NS = 2;
  localparam int IS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic             ready_b, valid_b, frame_b, busy_b;
  logic [NB*DW-1:0] data_b;
  logic [6:0]       col_b, row_b;

  logic             ready_s, valid_s, frame_s, busy_s;
  logic [NS*DW-1:0] data_s;
  logic [1:0]       col_s, row_s;

  int checks   = 0;
  int failures = 0;

  fmap_channel_packer #(.DATA_WIDTH(DW), .NUM_CH(NB), .IMG_SIZE(IB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_b), .data_out(data_b), .valid_out(valid_b), .pix_col(col_b),
    .pix_row(row_b), .frame_done(frame_b), .busy(busy_b)
  );

  fmap_channel_packer #(.DATA_WIDTH(DW), .NUM_CH(NS), .IMG_SIZE(IS)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_s), .data_out(data_s), .valid_out(valid_s), .pix_col(col_s),
    .pix_row(row_s), .frame_done(frame_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ready_b, valid_b, frame_b, busy_b, col_b, row_b} !== '0 || data_b !== '0) begin
      failures++;
      $display("FAIL reset_big: ctl=%b data=%h expected all zero",
               {ready_b, valid_b, frame_b, busy_b, col_b, row_b}, data_b);
    end
    checks++;
    if ({ready_s, valid_s, frame_s, busy_s, col_s, row_s} !== '0 || data_s !== '0) begin
      failures++;
      $display("FAIL reset_small: ctl=%b data=%h expected all zero",
               {ready_s, valid_s, frame_s, busy_s, col_s, row_s}, data_s);
    end
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h11;
    tick();
    data_in  = 32'h22;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_s !== 1'b1 || data_s !== {32'h22, 32'h11}) begin
      failures++;
      $display("FAIL prereset_pixel: valid=%b data=%h expected 1 %h", valid_s, data_s,
               {32'h22, 32'h11});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_s, valid_s, frame_s, busy_s, col_s, row_s} !== '0 || data_s !== '0) begin
      failures++;
      $display("FAIL async_reset_small: ctl=%b data=%h expected all zero",
               {ready_s, valid_s, frame_s, busy_s, col_s, row_s}, data_s);
    end
    checks++;
    if (ready_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_big: ready=%b busy=%b expected 0 0", ready_b, busy_b);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    logic [NB*DW-1:0] exp;
    int early;
    early = 0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ready_b !== 1'b1 || busy_b !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: ready=%b busy=%b expected 1 1", ready_b, busy_b);
    end
    for (int k = 0; k < NB; k++) begin
      valid_in = 1'b1;
      data_in  = 32'h3F800000 + 32'(k);
      exp[k*DW +: DW] = 32'h3F800000 + 32'(k);
      tick();
      if (k < NB - 1 && valid_b) early++;
    end
    valid_in = 1'b0;
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL single_early_pulse: got %0d early pulses expected 0", early);
    end
    checks++;
    if (valid_b !== 1'b1 || frame_b !== 1'b0 || col_b !== 7'd0 || row_b !== 7'd0) begin
      failures++;
      $display("FAIL single_ctl: valid=%b frame=%b col=%0d row=%0d expected 1 0 0 0",
               valid_b, frame_b, col_b, row_b);
    end
    checks++;
    if (data_b !== exp) begin
      failures++;
      $display("FAIL single_data: got %h expected %h", data_b, exp);
    end
    tick();
    checks++;
    if (valid_b !== 1'b0 || data_b !== exp) begin
      failures++;
      $display("FAIL single_hold: valid=%b data_ok=%b expected 0 1", valid_b, data_b === exp);
    end
  endtask

  task automatic test_gapped();
    logic [NB*DW-1:0] exp;
    int early;
    logic last_pulse;
    early = 0;
    last_pulse = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      valid_in = 1'b1;
      data_in  = 32'h3F800000 + 32'(k);
      exp[k*DW +: DW] = 32'h3F800000 + 32'(k);
      tick();
      if (k == NB - 1) last_pulse = valid_b;
      else if (valid_b) early++;
      valid_in = 1'b0;
      data_in  = 32'hDEADBEEF;
      tick();
      if (valid_b) early++;
    end
    checks++;
    if (last_pulse !== 1'b1 || early !== 0) begin
      failures++;
      $display("FAIL gapped_pulse: final=%b stray=%0d expected 1 0", last_pulse, early);
    end
    checks++;
    if (data_b !== exp) begin
      failures++;
      $display("FAIL gapped_data: got %h expected %h", data_b, exp);
    end
  endtask

  task automatic test_idle_valid();
    logic [NB*DW-1:0] exp;
    int stray;
    stray = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      valid_in = 1'b1;
      data_in  = 32'h55500000 + 32'(k);
      tick();
      if (valid_b || ready_b || busy_b) stray++;
    end
    valid_in = 1'b0;
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL idle_valid: got %0d active cycles expected 0", stray);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      valid_in = 1'b1;
      data_in  = 32'hA0000000 + 32'(k);
      exp[k*DW +: DW] = 32'hA0000000 + 32'(k);
      tick();
      if (k < NB - 1 && valid_b) stray++;
    end
    valid_in = 1'b0;
    checks++;
    if (stray !== 0 || valid_b !== 1'b1 || data_b !== exp) begin
      failures++;
      $display("FAIL idle_then_pixel: stray=%0d valid=%b data=%h expected 0 1 %h",
               stray, valid_b, data_b, exp);
    end
  endtask

  task automatic test_small_frame();
    int pulses;
    pulses = 0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < IS * IS * NS; i++) begin
      valid_in = 1'b1;
      data_in  = 32'(i);
      start    = (i == IS * IS * NS - 1);
      tick();
      start = 1'b0;
      if (valid_s) pulses++;
      checks++;
      if (i % 2 == 1) begin
        if (valid_s !== 1'b1 || col_s !== 2'((i / 2) % IS) || row_s !== 2'((i / 2) / IS) ||
            data_s !== {32'(i), 32'(i - 1)} || frame_s !== (i == IS * IS * NS - 1)) begin
          failures++;
          $display("FAIL frame_pixel_%0d: valid=%b col=%0d row=%0d frame=%b data=%h expected 1 %0d %0d %b %h",
                   i / 2, valid_s, col_s, row_s, frame_s, data_s, (i / 2) % IS, (i / 2) / IS,
                   (i == IS * IS * NS - 1), {32'(i), 32'(i - 1)});
        end
      end else begin
        if (valid_s !== 1'b0 || frame_s !== 1'b0) begin
          failures++;
          $display("FAIL frame_gap_%0d: valid=%b frame=%b expected 0 0", i, valid_s, frame_s);
        end
      end
    end
    valid_in = 1'b0;
    checks++;
    if (pulses !== IS * IS) begin
      failures++;
      $display("FAIL frame_pulse_count: got %0d expected %0d", pulses, IS * IS);
    end
    checks++;
    if (ready_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL frame_end_ready: ready=%b busy=%b expected 0 0", ready_s, busy_s);
    end
    tick();
    checks++;
    if (ready_s !== 1'b0 || frame_s !== 1'b0 || valid_s !== 1'b0) begin
      failures++;
      $display("FAIL restart_ignored: ready=%b frame=%b valid=%b expected 0 0 0",
               ready_s, frame_s, valid_s);
    end
  endtask

  task automatic test_start_in_run();
    int pulses;
    int frames;
    pulses = 0;
    frames = 0;
    do_reset();
    start = 1'b1;
    tick();
    start    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h100;
    tick();
    valid_in = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h101;
    tick();
    checks++;
    if (valid_s !== 1'b1 || data_s !== {32'h101, 32'h100} || col_s !== 2'd0 || row_s !== 2'd0) begin
      failures++;
      $display("FAIL start_in_run_pixel: valid=%b data=%h col=%0d row=%0d expected 1 %h 0 0",
               valid_s, data_s, col_s, row_s, {32'h101, 32'h100});
    end
    for (int i = 2; i < IS * IS * NS; i++) begin
      data_in = 32'h200 + 32'(i);
      tick();
      if (valid_s) pulses++;
      if (frame_s) frames++;
    end
    valid_in = 1'b0;
    checks++;
    if (pulses !== IS * IS - 1 || frames !== 1 || frame_s !== 1'b1 ||
        col_s !== 2'd3 || row_s !== 2'd3) begin
      failures++;
      $display("FAIL start_in_run_frame: pulses=%0d frames=%0d last_frame=%b col=%0d row=%0d expected 15 1 1 3 3",
               pulses, frames, frame_s, col_s, row_s);
    end
  endtask

  task automatic test_reset_mid_pixel();
    logic [NB*DW-1:0] exp;
    int pulses;
    pulses = 0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      valid_in = 1'b1;
      data_in  = 32'hBAD00000 + 32'(k);
      tick();
      if (valid_b) pulses++;
    end
    valid_in = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      valid_in = 1'b1;
      data_in  = 32'h40000000 + 32'(k);
      exp[k*DW +: DW] = 32'h40000000 + 32'(k);
      tick();
      if (valid_b) pulses++;
    end
    valid_in = 1'b0;
    checks++;
    if (pulses !== 1 || data_b !== exp || col_b !== 7'd0 || row_b !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_pixel: pulses=%0d col=%0d row=%0d data=%h expected 1 0 0 %h",
               pulses, col_b, row_b, data_b, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_gapped();
    test_idle_valid();
    test_small_frame();
    test_start_in_run();
    test_reset_mid_pixel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmap_channel_packer.md
# fmap_channel_packer

Packs a serial per-channel feature-map stream into the channel-parallel pixel words consumed by the layer feature-map convolution blocks. One DATA_WIDTH word per channel arrives per transfer. After NUM_CH channels the block emits one NUM_CH*DATA_WIDTH word with a single-cycle valid pulse, in raster order over one IMG_SIZE x IMG_SIZE frame. It sits between the feature-map buffer read side and each layer_N_featuremap_M input.

## Interface
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single, passed through untouched)
- NUM_CH, 32, channels per pixel; output word width is NUM_CH*DATA_WIDTH
- IMG_SIZE, 104, frame width and height in pixels
- Clk  in  1  single clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a frame
- data_in  in  DATA_WIDTH  channel sample
- valid_in  in  1  data_in valid
- ready_out  out  1  block accepts data_in this cycle
- data_out  out  NUM_CH*DATA_WIDTH  packed pixel; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_out  out  1  one-cycle pulse, data_out holds a new pixel
- pix_col  out  $clog2(IMG_SIZE)  column of the pixel on data_out
- pix_row  out  $clog2(IMG_SIZE)  row of the pixel on data_out
- frame_done  out  1  one-cycle pulse with the last pixel of the frame
- busy  out  1  high while in RUN

## Operation
- States: IDLE, RUN.
- IDLE:
  - ready_out=0 and busy=0.
  - valid_in is ignored.
  - start moves the block to RUN and clears ch_cnt, col_cnt and row_cnt.
- RUN:
  - ready_out=1 and busy=1.
  - A transfer happens on any cycle with valid_in=1 and ready_out=1.
  - Each transfer writes data_in into shadow slot ch_cnt, then increments ch_cnt.
- Pixel completion: a transfer with ch_cnt=NUM_CH-1 completes the pixel. On that edge:
  - data_out <= shadow with slot NUM_CH-1 replaced by the current data_in.
  - valid_out <= 1.
  - pix_col/pix_row <= col_cnt/row_cnt.
  - ch_cnt wraps to 0.
  - col_cnt increments. At IMG_SIZE-1, col_cnt wraps to 0 and row_cnt increments.
- Frame completion: the pixel completion with col_cnt=IMG_SIZE-1 and row_cnt=IMG_SIZE-1 also:
  - sets frame_done <= 1 on the same edge as the final valid_out;
  - returns the state to IDLE, so ready_out=0 on the following cycle.
- There is no output backpressure. The next pixel's channels are accepted on the cycle immediately after a completion, and the shadow is reused.
- start while in RUN is ignored. The frame is not restarted.
- Gaps in valid_in are allowed anywhere. Partial-pixel state is held indefinitely.
- Data is not modified; this is bit-exact packing only.

## Timing
- Reset values:
  - state=IDLE.
  - ready_out=0, valid_out=0, frame_done=0, busy=0.
  - data_out=0, pix_col=0, pix_row=0.
  - Shadow registers and all counters are 0.
- Start latency: start sampled high at edge t gives ready_out=1 from t+1.
- Pixel latency:
  - valid_out is high for exactly the cycle after the edge that accepts channel NUM_CH-1.
  - With continuous valid_in, valid_out pulses every NUM_CH cycles.
- Hold: data_out, pix_col and pix_row hold their values between pulses.
- Frame: exactly IMG_SIZE*IMG_SIZE valid_out pulses and one frame_done per started frame.
- Reset mid-operation: asserting Rst at any time returns all state to the reset values. A partial pixel is discarded and nothing is emitted for it.
- Restart: start in the same cycle as frame_done is ignored, because the block is still in RUN. A new frame needs start on a later cycle.

## Test plan
- Reset check: assert Rst low mid-stream -> all outputs 0, state IDLE, ready_out=0.
- Single pixel (NUM_CH=32):
  - Stimulus: start, then 32 back-to-back samples with data_in=32'h3F800000+k.
  - Response: one valid_out pulse 1 cycle after the 32nd sample; data_out[k*32+:32]=32'h3F800000+k; pix_col=0, pix_row=0.
- Gapped input:
  - Stimulus: the same 32 samples with valid_in low on every other cycle.
  - Response: identical data_out; valid_out only after the 32nd accepted sample.
- Full small frame (IMG_SIZE=4, NUM_CH=2):
  - Stimulus: start, then 32 continuous samples.
  - Response: 16 valid_out pulses 2 cycles apart. pix_col/pix_row walk 0..3 in raster order. frame_done coincides with the 16th pulse. ready_out=0 on the next cycle.
- Illegal events:
  - valid_in in IDLE -> no effect.
  - start in RUN mid-pixel -> no counter reset; the frame completes normally.
- Reset mid-pixel:
  - Stimulus: 10 of 32 channels, then Rst pulse, then start and a full pixel.
  - Response: exactly one valid_out, containing only the post-reset samples.
